// File: rtl/filter_pkg.sv
// Shared types and constants for the filter output path.
package filter_pkg;

  // Width of one filter output sample.
  localparam int unsigned SAMPLE_W = 18;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    CAPTURE,
    READOUT
  } capture_state_t;

endpackage

// File: rtl/capture_ram.sv
// Single-port sample buffer with registered (one-cycle latency) read.
module capture_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned W     = 18
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write and read share one address; the two are never requested together.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sample_capture.sv
// Captures a programmed run of strobed filter samples, then replays them on a
// ready/valid stream with a last marker.
module sample_capture
  import filter_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned W     = SAMPLE_W,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   skip,
  input  logic [LW-1:0] len,
  input  logic          dv_in,
  input  logic [W-1:0]  d_in,
  output logic          m_valid,
  output logic [W-1:0]  m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy,
  output logic          done
);

  localparam int unsigned   AW      = LW - 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  capture_state_t state_q, state_d;
  logic [15:0]    skip_q, skip_d;
  logic [LW-1:0]  len_q, len_d;
  logic [LW-1:0]  wa_q, wa_d;
  logic [LW-1:0]  ra_q, ra_d;
  logic           zero_q, zero_d;
  logic           rd_pend_q, rd_pend_d;
  logic           rd_last_q, rd_last_d;

  // Two-entry skid FIFO fed by the RAM read port.
  logic [W-1:0]   fifo_data_q [2];
  logic [W-1:0]   fifo_data_d [2];
  logic [1:0]     fifo_last_q, fifo_last_d;
  logic           wr_ptr_q, wr_ptr_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic [1:0]     cnt_q, cnt_d;

  logic           ram_we, ram_re;
  logic [AW-1:0]  ram_addr;
  logic [W-1:0]   ram_rdata;
  logic [LW-1:0]  len_clamped;
  logic [LW-1:0]  wa_inc;
  logic [1:0]     occ;
  logic           pop;
  logic           last_accept;

  assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
  assign wa_inc      = wa_q + ONE_L;
  // Entries held plus the read still in flight; never exceeds the FIFO size.
  assign occ         = cnt_q + {1'b0, rd_pend_q};

  assign m_valid     = (cnt_q != 2'd0);
  assign m_data      = fifo_data_q[rd_ptr_q];
  assign m_last      = m_valid & fifo_last_q[rd_ptr_q];
  assign pop         = m_valid & m_ready;
  assign last_accept = pop & m_last;
  assign busy        = (state_q != IDLE);
  // Suppressed while rst is high so an abort never reports completion.
  assign done        = ~rst & (zero_q | last_accept);

  capture_ram #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (d_in),
    .rdata (ram_rdata)
  );

  // FSM next state, counters and RAM control.
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    len_d     = len_q;
    wa_d      = wa_q;
    ra_d      = ra_q;
    zero_d    = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = wa_q[AW-1:0];
    rd_last_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          skip_d = skip;
          len_d  = len_clamped;
          wa_d   = '0;
          ra_d   = '0;
          if (len_clamped == '0) begin
            zero_d = 1'b1;
          end else if (skip != 16'd0) begin
            state_d = SKIP;
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      SKIP: begin
        if (dv_in) begin
          skip_d = skip_q - 16'd1;
          if (skip_q == 16'd1) begin
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (dv_in) begin
          ram_we = 1'b1;
          wa_d   = wa_inc;
          if (wa_inc == len_q) begin
            state_d = READOUT;
          end
        end
      end
      READOUT: begin
        ram_addr = ra_q[AW-1:0];
        // Issue a read whenever a FIFO slot will be free when its data lands.
        if ((ra_q != len_q) && ((occ - {1'b0, pop}) < 2'd2)) begin
          ram_re    = 1'b1;
          ra_d      = ra_q + ONE_L;
          rd_last_d = (ra_q == len_q - ONE_L);
        end
        if (last_accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_pend_d = ram_re;

  // Skid FIFO next state: push returning read data, pop on downstream accept.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (rd_pend_q) begin
      fifo_data_d[wr_ptr_q] = ram_rdata;
      fifo_last_d[wr_ptr_q] = rd_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      skip_q      <= '0;
      len_q       <= '0;
      wa_q        <= '0;
      ra_q        <= '0;
      zero_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_last_q   <= 1'b0;
      fifo_data_q <= '{default: '0};
      fifo_last_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      len_q       <= len_d;
      wa_q        <= wa_d;
      ra_q        <= ra_d;
      zero_q      <= zero_d;
      rd_pend_q   <= rd_pend_d;
      rd_last_q   <= rd_last_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
